w5300_bus_arbiter: RTL
======================

// Module: w5300_bus_arbiter
//
// PURPOSE
//   Shares the single W5300 register-bus driver between NUM_CLIENTS socket engines
//   (per-socket transmitters and receivers) using rotating-priority arbitration.
//   The granted client's addr/wr_data command goes to the driver. The driver's
//   op_state completion pulse returns only to that client; rd_data goes to all clients.
//   Also enforces a per-grant operation budget and a hang watchdog.
//
// PARAMETERS
//   NUM_CLIENTS  4     number of requesters, 2..8
//   ADDR_W       10    command address width (driver op-encoded register address)
//   DATA_W       16    bus data width
//   MAX_BURST    64    ops per grant before yielding to a waiting client; 0 = unlimited
//   TIMEOUT      1024  cycles in GRANT with no op_done before forced release; 0 = off
//
// PORTS
//   clk           in   1                    system clock
//   rst_n         in   1                    synchronous active-low reset
//   cli_req       in   NUM_CLIENTS          per-client bus request, level
//   cli_addr      in   NUM_CLIENTS*ADDR_W   per-client command address, client i at [i*ADDR_W +: ADDR_W]
//   cli_wr_data   in   NUM_CLIENTS*DATA_W   per-client write data, same packing
//   cli_gnt       out  NUM_CLIENTS          one-hot grant, registered
//   cli_op_state  out  NUM_CLIENTS          op-done pulse, routed to the granted client only
//   cli_rd_data   out  DATA_W               read data, broadcast (= drv_rd_data)
//   drv_addr      out  ADDR_W               command to the bus driver
//   drv_wr_data   out  DATA_W               write data to the bus driver
//   drv_en        out  1                    driver may start operations
//   drv_rd_data   in   DATA_W               read data from the driver
//   drv_op_state  in   1                    driver op-complete pulse, 1 cycle
//   arb_timeout   out  1                    1-cycle pulse on watchdog release
//
// BEHAVIOUR
//   FSM states: IDLE, GRANT, RELEASE. Reset state is IDLE.
//   Reset values: cli_gnt=0, cli_op_state=0, drv_en=0, drv_addr=0, drv_wr_data=0,
//   arb_timeout=0, rr_ptr=0, op_cnt=0, wd_cnt=0.
//   IDLE:
//     - If cli_req != 0, select the first requester scanning from rr_ptr upward, modulo NUM_CLIENTS.
//     - Register cli_gnt one-hot and move to GRANT. Latency is 1 clk from req to gnt.
//   GRANT:
//     - drv_addr/drv_wr_data = granted client's command (combinational mux); drv_en=1.
//     - cli_op_state[g] = drv_op_state; all other bits of cli_op_state are 0.
//     - op_cnt increments on each drv_op_state pulse; wd_cnt clears on drv_op_state and
//       otherwise increments.
//     - Exit to RELEASE when any of the following holds:
//       (a) cli_req[g] == 0;
//       (b) MAX_BURST != 0, op_cnt has reached MAX_BURST, and another request is pending;
//       (c) TIMEOUT != 0 and wd_cnt reaches TIMEOUT-1. This also pulses arb_timeout.
//     - For (b), the exit is taken only in the cycle drv_op_state pulses, so no op is cut.
//     - If req drops in the same cycle as drv_op_state, the pulse is still delivered.
//   RELEASE (1 clk):
//     - cli_gnt=0, drv_en=0, drv_addr/drv_wr_data=0 (idle read of reg 0x000).
//     - rr_ptr <= (g+1) mod NUM_CLIENTS; op_cnt=0; wd_cnt=0; go to IDLE.
//     - Minimum gap between grants is 2 clk (RELEASE + IDLE).
//   Outside GRANT: drv_addr=0, drv_wr_data=0, drv_en=0, cli_op_state=0.
//   Clients hold their command stable and stall while their cli_gnt bit is 0.
//   A preempted client keeps req high and regains the bus in its rotation.
//   op_cnt and wd_cnt saturate and never wrap.
//   rr_ptr wraps from NUM_CLIENTS-1 to 0.
//   Reset mid-GRANT: outputs return to reset values on the next clk. Any in-flight
//   driver op completion is dropped (cli_op_state=0).
//
// TESTING
//   1. Single req: cli_req=4'b0100 -> cli_gnt=4'b0100 one clk later. Drop req ->
//      RELEASE, gnt=0 and rr_ptr=3 after 1 clk.
//   2. Rotation: all four req held, MAX_BURST=2, driver pulses op_state every 3 clk ->
//      grant order 0,1,2,3,0, each holding exactly 2 ops.
//   3. Routing: client 1 granted, drv_rd_data=16'hBEEF, pulse op_state ->
//      cli_op_state=4'b0010 and cli_rd_data=16'hBEEF.
//   4. Watchdog: TIMEOUT=16, grant held, no op_state -> arb_timeout pulses at clk 16
//      of GRANT, gnt drops, next requester granted.
//   5. Budget without contention: only client 0 requesting, MAX_BURST=2 -> grant kept
//      across 5 ops, no release.
//   6. rst_n low mid-GRANT for 1 clk -> all outputs 0, state IDLE, rr_ptr=0;
//      pending req regranted 1 clk after rst_n high.

Source files
------------

// File: rtl/w5300_bus_arbiter_if.sv
// Bundle of client-side and driver-side signals around the W5300 bus arbiter.
// Latency: none (wires only).
// Backpressure: clients stall on their cli_gnt bit; the driver is gated by drv_en.
interface w5300_bus_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16
);
  logic [NUM_CLIENTS-1:0]        cli_req;
  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] cli_wr_data;
  logic [NUM_CLIENTS-1:0]        cli_gnt;
  logic [NUM_CLIENTS-1:0]        cli_op_state;
  logic [DATA_W-1:0]             cli_rd_data;
  logic [ADDR_W-1:0]             drv_addr;
  logic [DATA_W-1:0]             drv_wr_data;
  logic                          drv_en;
  logic [DATA_W-1:0]             drv_rd_data;
  logic                          drv_op_state;
  logic                          arb_timeout;

  // Arbiter side
  modport slave (
    input  cli_req, cli_addr, cli_wr_data, drv_rd_data, drv_op_state,
    output cli_gnt, cli_op_state, cli_rd_data, drv_addr, drv_wr_data, drv_en, arb_timeout
  );

  // Socket engines and bus driver side
  modport master (
    output cli_req, cli_addr, cli_wr_data, drv_rd_data, drv_op_state,
    input  cli_gnt, cli_op_state, cli_rd_data, drv_addr, drv_wr_data, drv_en, arb_timeout
  );
endinterface

// File: rtl/w5300_bus_arbiter.sv
// Rotating-priority arbiter sharing one W5300 register-bus driver among socket engines.
// Latency: 1 clk req->gnt; 2 clk minimum gap between grants (RELEASE + IDLE).
// Backpressure: non-granted clients stall on cli_gnt; grants yield on budget or watchdog.
module w5300_bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int MAX_BURST   = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  w5300_bus_arbiter_if.slave    bus
);
  localparam int IW  = $clog2(NUM_CLIENTS);
  localparam int OPW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OPW-1:0] BURST_LIM = OPW'(MAX_BURST);
  localparam logic [WDW-1:0] WD_LIM    = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW:0]    NC        = (IW + 1)'(NUM_CLIENTS);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_CLIENTS-1:0] gnt;
  logic [IW-1:0]          g_idx;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          rr_nxt;
  logic [IW-1:0]          sel_idx;
  logic [IW-1:0]          sel_off;
  logic                   sel_vld;
  logic [IW:0]            sel_sum;
  logic [IW:0]            g_inc;
  logic [2*NUM_CLIENTS-1:0] req_dbl;
  logic [NUM_CLIENTS-1:0] req_rot;
  logic [OPW-1:0]         op_cnt, op_cnt_nxt;
  logic [WDW-1:0]         wd_cnt, wd_cnt_nxt;
  logic                   req_g, others_pend, burst_hit, wd_hit, grant_exit;

  // Rotate requests so bit 0 is the client at rr_ptr, then pick the lowest set offset
  assign req_dbl = {bus.cli_req, bus.cli_req};
  assign req_rot = NUM_CLIENTS'(req_dbl >> rr_ptr);

  // Find the first requester at or after rr_ptr, wrapping modulo NUM_CLIENTS
  always_comb begin
    sel_vld = 1'b0;
    sel_off = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sel_vld = 1'b1;
        sel_off = IW'(k);
      end
    end
    sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
    sel_idx = (sel_sum >= NC) ? IW'(sel_sum - NC) : IW'(sel_sum);
  end

  // Grant-exit conditions; the budget exit only fires on a completion so no op is cut
  assign req_g       = |(bus.cli_req & gnt);
  assign others_pend = |(bus.cli_req & ~gnt);
  assign op_cnt_nxt  = (bus.drv_op_state && (op_cnt != '1)) ? op_cnt + OPW'(1) : op_cnt;
  assign wd_cnt_nxt  = bus.drv_op_state ? '0 : ((wd_cnt != '1) ? wd_cnt + WDW'(1) : wd_cnt);
  assign burst_hit   = (MAX_BURST != 0) && bus.drv_op_state && (op_cnt_nxt >= BURST_LIM) && others_pend;
  assign wd_hit      = (TIMEOUT != 0) && (wd_cnt >= WD_LIM);
  assign grant_exit  = !req_g || burst_hit || wd_hit;
  assign g_inc       = {1'b0, g_idx} + (IW + 1)'(1);
  assign rr_nxt      = (g_inc >= NC) ? '0 : IW'(g_inc);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = GRANT;
      GRANT:   if (grant_exit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, rotation pointer and per-grant counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt    <= '0;
      g_idx  <= '0;
      rr_ptr <= '0;
      op_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            g_idx <= sel_idx;
            gnt   <= NUM_CLIENTS'(1) << sel_idx;
          end
        end
        GRANT: begin
          op_cnt <= op_cnt_nxt;
          wd_cnt <= wd_cnt_nxt;
          if (grant_exit) gnt <= '0;
        end
        RELEASE: begin
          rr_ptr <= rr_nxt;
          op_cnt <= '0;
          wd_cnt <= '0;
        end
        default: gnt <= '0;
      endcase
    end
  end

  // Driver command mux and completion routing, active only while granted
  always_comb begin
    bus.drv_addr     = '0;
    bus.drv_wr_data  = '0;
    bus.drv_en       = 1'b0;
    bus.cli_op_state = '0;
    bus.arb_timeout  = 1'b0;
    if (state == GRANT) begin
      bus.drv_en       = 1'b1;
      bus.cli_op_state = gnt & {NUM_CLIENTS{bus.drv_op_state}};
      bus.arb_timeout  = wd_hit;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (g_idx == IW'(i)) begin
          bus.drv_addr    = bus.cli_addr[i*ADDR_W +: ADDR_W];
          bus.drv_wr_data = bus.cli_wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.cli_gnt     = gnt;
  assign bus.cli_rd_data = bus.drv_rd_data;
endmodule
